// File: rtl/press_decoder.sv
// Classifies debounced switch press/release pulses into short, long and double
// presses, with a running count of classified events.
module press_decoder #(
  parameter int LONG_CLKS = 50,
  parameter int DBL_CLKS  = 20
) (
  input  logic       clk50m,
  input  logic       rst_n,
  input  logic       sw_hi,
  input  logic       sw_lo,
  output logic       short_p,
  output logic       long_p,
  output logic       dbl_p,
  output logic       busy,
  output logic [7:0] evt_cnt
);

  // state  | meaning
  // IDLE   | waiting for a first press
  // PRESS1 | first press held, long timer running
  // LONG   | long press already reported, waiting for release
  // WAIT2  | released, waiting for a second press within the gap
  // PRESS2 | second press held, double reported on release
  typedef enum logic [2:0] {IDLE, PRESS1, LONG, WAIT2, PRESS2} state_t;

  // tmr reads N-1 on the Nth cycle after entering a state. Timeout pulses are
  // registered one cycle early so they appear exactly on the timeout cycle.
  localparam logic [15:0] LONG_LAST = 16'(LONG_CLKS - 1);
  localparam logic [15:0] LONG_WARN = 16'(LONG_CLKS - 2);
  localparam logic [15:0] DBL_LAST  = 16'(DBL_CLKS - 1);
  localparam logic [15:0] DBL_WARN  = 16'(DBL_CLKS - 2);

  state_t      state;
  logic [15:0] tmr;
  logic        hi_only;
  logic        lo_only;

  // Simultaneous press and release pulses cancel each other out.
  assign hi_only = sw_hi & ~sw_lo;
  assign lo_only = sw_lo & ~sw_hi;

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmr     <= '0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      dbl_p   <= 1'b0;
      busy    <= 1'b0;
      evt_cnt <= '0;
    end else begin
      short_p <= 1'b0;
      long_p  <= 1'b0;
      dbl_p   <= 1'b0;
      if (tmr != 16'hFFFF) tmr <= tmr + 16'd1;
      case (state)
        IDLE: begin
          if (hi_only) begin
            state <= PRESS1;
            tmr   <= '0;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          if (tmr >= LONG_LAST) begin
            state <= LONG;
            tmr   <= '0;
          end else if (lo_only) begin
            state <= WAIT2;
            tmr   <= '0;
          end else if (tmr == LONG_WARN) begin
            long_p  <= 1'b1;
            evt_cnt <= evt_cnt + 8'd1;
          end
        end
        LONG: begin
          if (lo_only) begin
            state <= IDLE;
            tmr   <= '0;
            busy  <= 1'b0;
          end
        end
        WAIT2: begin
          if (tmr >= DBL_LAST) begin
            state <= IDLE;
            tmr   <= '0;
            busy  <= 1'b0;
          end else if (hi_only) begin
            state <= PRESS2;
            tmr   <= '0;
          end else if (tmr == DBL_WARN) begin
            short_p <= 1'b1;
            evt_cnt <= evt_cnt + 8'd1;
          end
        end
        PRESS2: begin
          if (lo_only) begin
            state   <= IDLE;
            tmr     <= '0;
            busy    <= 1'b0;
            dbl_p   <= 1'b1;
            evt_cnt <= evt_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          tmr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder: directed timing scenarios with literal expectations
// plus randomized pulse streams checked every cycle against a timestamp model.
module tb_press_decoder;

  localparam int LONG = 50;
  localparam int DBL  = 20;

  logic       clk50m = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sw_hi  = 1'b0;
  logic       sw_lo  = 1'b0;
  logic       short_p, long_p, dbl_p, busy;
  logic [7:0] evt_cnt;

  press_decoder #(.LONG_CLKS(LONG), .DBL_CLKS(DBL)) dut (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .sw_hi  (sw_hi),
    .sw_lo  (sw_lo),
    .short_p(short_p),
    .long_p (long_p),
    .dbl_p  (dbl_p),
    .busy   (busy),
    .evt_cnt(evt_cnt)
  );

  always #5 clk50m = ~clk50m;

  // Model: which phase of a gesture we are in and when that phase began.
  typedef enum int {M_IDLE, M_HELD1, M_HELD_LONG, M_GAP, M_HELD2} mode_t;
  mode_t      mode = M_IDLE;
  int         t0 = 0;
  logic       x_short = 1'b0, x_long = 1'b0, x_dbl = 1'b0, x_busy = 1'b0;
  logic [7:0] x_cnt = '0;

  int cyc = 0;
  int base = 0;
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int n_short = 0, n_long = 0, n_dbl = 0;
  int short_at = -1, long_at = -1, dbl_at = -1, last_busy = -1;

  // Inputs sampled on cycle cyc; outputs predicted for cycle cyc+1.
  task automatic model(input logic hi, input logic lo, input logic rn);
    bit hon = hi && !lo;
    bit lon = lo && !hi;
    int e;
    x_short = 1'b0;
    x_long  = 1'b0;
    x_dbl   = 1'b0;
    if (!rn) begin
      mode   = M_IDLE;
      x_cnt  = '0;
      x_busy = 1'b0;
      return;
    end
    e = cyc - t0;
    case (mode)
      M_IDLE:      if (hon) begin mode = M_HELD1; t0 = cyc; end
      M_HELD1:     if (e >= LONG) mode = M_HELD_LONG;
                   else if (lon) begin mode = M_GAP; t0 = cyc; end
      M_HELD_LONG: if (lon) mode = M_IDLE;
      M_GAP:       if (e >= DBL) mode = M_IDLE;
                   else if (hon) mode = M_HELD2;
      M_HELD2:     if (lon) begin mode = M_IDLE; x_dbl = 1'b1; end
      default:     mode = M_IDLE;
    endcase
    if (mode == M_HELD1 && cyc + 1 - t0 == LONG) x_long = 1'b1;
    if (mode == M_GAP && cyc + 1 - t0 == DBL) x_short = 1'b1;
    x_busy = (mode != M_IDLE);
    if (x_short || x_long || x_dbl) x_cnt = x_cnt + 8'd1;
  endtask

  task automatic compare_cycle();
    if (!chk_en) return;
    n_vec++;
    if (short_p !== x_short || long_p !== x_long || dbl_p !== x_dbl ||
        busy !== x_busy || evt_cnt !== x_cnt) begin
      n_err++;
      if (n_err < 30)
        $display("FAIL cycle %0d outputs: got s/l/d/b/cnt=%b%b%b%b/%0d expected %b%b%b%b/%0d",
                 cyc, short_p, long_p, dbl_p, busy, evt_cnt,
                 x_short, x_long, x_dbl, x_busy, x_cnt);
    end
  endtask

  task automatic step(input logic hi, input logic lo, input logic rn);
    sw_hi = hi;
    sw_lo = lo;
    rst_n = rn;
    @(posedge clk50m);
    model(hi, lo, rn);
    cyc++;
    @(negedge clk50m);
    compare_cycle();
    if (short_p) begin n_short++; short_at = cyc - base; end
    if (long_p)  begin n_long++;  long_at  = cyc - base; end
    if (dbl_p)   begin n_dbl++;   dbl_at   = cyc - base; end
    if (busy) last_busy = cyc - base;
    chk_en = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int s0, l0, d0;

  // Relative cycle times; -1 means unused.
  task automatic scn(input int h0, input int h1, input int lo0, input int lo1,
                     input int rf, input int rt, input int len, input bit do_rst);
    if (do_rst) step(1'b0, 1'b0, 1'b0);
    s0 = n_short; l0 = n_long; d0 = n_dbl;
    short_at = -1; long_at = -1; dbl_at = -1; last_busy = -1;
    base = cyc;
    for (int r = 0; r < len; r++)
      step(r == h0 || r == h1, r == lo0 || r == lo1, !(r >= rf && r <= rt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int tot_short;
  int p;

  initial begin
    step(1'b0, 1'b0, 1'b0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(evt_cnt), 0);
    chk("reset_pulses", int'(short_p) + int'(long_p) + int'(dbl_p), 0);

    // Single short press.
    scn(0, -1, 5, -1, -1, -1, 40, 1'b1);
    chk("short_at", short_at, 25);
    chk("short_count", n_short - s0, 1);
    chk("short_others", (n_long - l0) + (n_dbl - d0), 0);
    chk("short_busy_low_from", last_busy + 1, 26);
    chk("short_evt_cnt", int'(evt_cnt), 1);

    // Long press with late release.
    scn(0, -1, 80, -1, -1, -1, 100, 1'b1);
    chk("long_at", long_at, 50);
    chk("long_count", n_long - l0, 1);
    chk("long_others", (n_short - s0) + (n_dbl - d0), 0);
    chk("long_busy_low_from", last_busy + 1, 81);
    chk("long_evt_cnt", int'(evt_cnt), 1);

    // Double press.
    scn(0, 15, 5, 20, -1, -1, 50, 1'b1);
    chk("dbl_at", dbl_at, 21);
    chk("dbl_count", n_dbl - d0, 1);
    chk("dbl_no_short", n_short - s0, 0);
    chk("dbl_evt_cnt", int'(evt_cnt), 1);

    // Second press exactly on gap timeout is dropped.
    scn(0, 25, 5, -1, -1, -1, 60, 1'b1);
    chk("late2_short_at", short_at, 25);
    chk("late2_pulses", (n_short - s0) + (n_long - l0) + (n_dbl - d0), 1);
    chk("late2_last_busy", last_busy, 25);

    // Reset mid-press aborts silently.
    scn(0, -1, 20, -1, 10, 12, 80, 1'b1);
    chk("rst_pulses", (n_short - s0) + (n_long - l0) + (n_dbl - d0), 0);
    chk("rst_last_busy", last_busy, 10);
    chk("rst_evt_cnt", int'(evt_cnt), 0);

    // Release on the last cycle before long still counts as short.
    scn(0, -1, 49, -1, -1, -1, 80, 1'b1);
    chk("edge49_short_at", short_at, 69);
    chk("edge49_no_long", n_long - l0, 0);

    // Release on the long timeout cycle loses; next release ends it.
    scn(0, -1, 50, 60, -1, -1, 80, 1'b1);
    chk("edge50_long_at", long_at, 50);
    chk("edge50_no_short", n_short - s0, 0);
    chk("edge50_busy_low_from", last_busy + 1, 61);

    // Second press on the last legal gap cycle.
    scn(0, 24, 5, 30, -1, -1, 60, 1'b1);
    chk("edge24_dbl_at", dbl_at, 31);
    chk("edge24_no_short", n_short - s0, 0);

    // evt_cnt wrap across 256 short presses.
    step(1'b0, 1'b0, 1'b0);
    tot_short = 0;
    for (int k = 0; k < 256; k++) begin
      scn(0, -1, 5, -1, -1, -1, 30, 1'b0);
      tot_short += n_short - s0;
      if (k == 254) chk("wrap_cnt_255", int'(evt_cnt), 255);
    end
    chk("wrap_cnt_0", int'(evt_cnt), 0);
    chk("wrap_short_total", tot_short, 256);

    // Randomized pulse streams with varying density.
    for (int blk = 0; blk < 30; blk++) begin
      p = int'($urandom_range(3, 60));
      for (int r = 0; r < 200; r++)
        step(($urandom % p) == 0, ($urandom % p) == 0, ($urandom % 300) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/press_decoder.md
PRESS_DECODER -- requirements
Module: press_decoder

Interface
REQ-001 Parameter LONG_CLKS, default 50, hold duration in clk50m cycles that classifies a press as long; legal range 2..65535.
REQ-002 Parameter DBL_CLKS, default 20, maximum release-to-press gap in clk50m cycles for a double press; legal range 2..65535.
REQ-003 Port clk50m  input  1  system clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk50m.
REQ-005 Port sw_hi  input  1  one-cycle pulse: debounced switch went high (press).
REQ-006 Port sw_lo  input  1  one-cycle pulse: debounced switch went low (release).
REQ-007 Port short_p  output  1  one-cycle pulse: single short press classified.
REQ-008 Port long_p  output  1  one-cycle pulse: long press classified.
REQ-009 Port dbl_p  output  1  one-cycle pulse: double press classified.
REQ-010 Port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 Port evt_cnt  output  8  count of classified events (short + long + dbl).

Function
REQ-012 The FSM SHALL have states IDLE, PRESS1, LONG, WAIT2, PRESS2; all outputs SHALL be registered.
REQ-013 A 16-bit timer tmr SHALL be cleared on every state change and SHALL increment once per cycle otherwise, saturating at 65535.
REQ-014 Cycle numbering: the cycle in which an input pulse is sampled is cycle 0.
REQ-015 IDLE: sw_hi -> PRESS1; sw_lo ignored.
REQ-016 PRESS1: sw_lo at cycle 1..LONG_CLKS-1 after sw_hi -> WAIT2; otherwise, at cycle LONG_CLKS after sw_hi, long_p SHALL be high for exactly that cycle and the FSM SHALL enter LONG.
REQ-017 LONG: no further pulses; sw_lo -> IDLE; sw_hi ignored.
REQ-018 WAIT2: sw_hi at cycle 1..DBL_CLKS-1 after sw_lo -> PRESS2; otherwise, at cycle DBL_CLKS after sw_lo, short_p SHALL be high for exactly that cycle and the FSM SHALL enter IDLE.
REQ-019 PRESS2: sw_lo -> dbl_p high in the following cycle (cycle 1) and the FSM SHALL enter IDLE; hold duration in PRESS2 is unbounded and never yields long_p.
REQ-020 At most one of short_p, long_p, dbl_p SHALL be high in any cycle.
REQ-021 evt_cnt SHALL increment by 1 in the same cycle that any of short_p/long_p/dbl_p is high, wrapping 255 -> 0.
REQ-022 sw_hi and sw_lo high in the same cycle SHALL be treated as no event in every state; tmr continues normally.
REQ-023 sw_lo in the same cycle as a timeout in PRESS1 (cycle LONG_CLKS) SHALL lose: long_p fires and the FSM enters LONG, where that sw_lo is not seen; the next sw_lo returns the FSM to IDLE.
REQ-024 sw_hi in the same cycle as a timeout in WAIT2 (cycle DBL_CLKS) SHALL lose: short_p fires, FSM enters IDLE, that sw_hi is dropped.
REQ-025 busy SHALL be high from the cycle after sw_hi in IDLE until the cycle after the FSM returns to IDLE.

Reset
REQ-026 While rst_n is low at a rising edge of clk50m: state=IDLE, tmr=0, short_p=long_p=dbl_p=0, busy=0, evt_cnt=0.
REQ-027 Reset asserted mid-press or mid-gap SHALL abort the sequence with no pulse emitted; after release the FSM SHALL stay in IDLE until a fresh sw_hi (a pending sw_lo is ignored).

Verification
REQ-028 Defaults. sw_hi at cycle 0, sw_lo at cycle 5, nothing else -> short_p high only at cycle 25, evt_cnt 0->1, busy low from cycle 26.
REQ-029 Defaults. sw_hi at 0, no sw_lo until cycle 80 -> long_p high only at cycle 50, no pulse at release, busy low from cycle 81, evt_cnt=1.
REQ-030 Defaults. sw_hi 0, sw_lo 5, sw_hi 15, sw_lo 20 -> dbl_p high only at cycle 21, no short_p, evt_cnt=1.
REQ-031 Defaults. sw_hi 0, sw_lo 5, sw_hi 25 -> short_p at 25, second sw_hi dropped, FSM in IDLE at cycle 26, no further pulses.
REQ-032 Defaults. sw_hi 0, rst_n low for cycles 10..12, sw_lo at 20 -> no pulses, busy=0 from cycle 11 on, evt_cnt=0.
REQ-033 256 consecutive short-press sequences -> evt_cnt returns to 0 and exactly 256 short_p pulses are counted by the bench.
